// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery multiplier sequencer.
package mont_pkg;

  localparam int unsigned N       = 512;
  localparam int unsigned W_ADD   = N + 2;
  localparam int unsigned NPHASE  = 5;
  localparam int unsigned MAX_SUB = 4;
  localparam int unsigned CNT_W   = $clog2(N);
  localparam int unsigned SUB_W   = $clog2(MAX_SUB + 1);

  localparam logic [3:0] PHASE_IDLE = 4'd8;
  localparam logic [3:0] PHASE_LAST = 4'(NPHASE - 1);

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t ADD_B   = 3'd1;
  localparam state_t ADD_M   = 3'd2;
  localparam state_t SHIFT   = 3'd3;
  localparam state_t RESOLVE = 3'd4;
  localparam state_t SUB     = 3'd5;
  localparam state_t DONE    = 3'd6;

  // Strobes sent to the carry-save adder, registered as one bundle.
  typedef struct packed {
    logic enable_c;
    logic shift;
    logic subtract;
  } add_ctrl_t;

endpackage

// File: rtl/mont_phase_cnt.sv
// Carry-propagate phase counter: 0..NPHASE-1 with wrap, parked at PHASE_IDLE while held.
module mont_phase_cnt
  import mont_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       hold,
  output logic [3:0] phase,
  output logic       last_c
);

  // Leaving the idle code or finishing a sweep always restarts at phase 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase <= PHASE_IDLE;
    end else if (hold) begin
      phase <= PHASE_IDLE;
    end else if ((phase == PHASE_LAST) || (phase == PHASE_IDLE)) begin
      phase <= 4'd0;
    end else begin
      phase <= phase + 4'd1;
    end
  end

  assign last_c = (phase == PHASE_LAST);

endmodule

// File: rtl/mont_mul_ctrl.sv
// Sequencer for one radix-2 Montgomery product R = A*B*2^-N mod M on mpadder.
module mont_mul_ctrl
  import mont_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [N-1:0]     in_m,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N-1:0]     result,
  output logic [W_ADD-1:0] add_in_a,
  output logic             add_enableC,
  output logic             add_shift,
  output logic             add_subtract,
  output logic [3:0]       add_phase,
  input  logic             add_cZero,
  input  logic             add_carry,
  input  logic [W_ADD-1:0] add_result
);

  state_t           state;
  state_t           next_state;
  logic [N-1:0]     a_sr;
  logic [N-1:0]     b_q;
  logic [N-1:0]     m_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [SUB_W-1:0] sub_cnt;
  add_ctrl_t        ctrl_q;
  add_ctrl_t        ctrl_d;
  logic             sub_fail;
  logic             phase_hold;
  logic             phase_last;
  logic             unused_res_hi;

  // Guard bits of the adder result are not part of the N-bit product.
  assign unused_res_hi = ^add_result[W_ADD-1:N];

  mont_phase_cnt u_phase (
    .clk    (clk),
    .resetn (resetn),
    .hold   (phase_hold),
    .phase  (add_phase),
    .last_c (phase_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus look-ahead of the registered adder strobes.
  always_comb begin
    next_state = state;
    sub_fail   = 1'b0;
    ctrl_d     = '0;
    phase_hold = 1'b1;
    case (state)
      IDLE:    if (start) next_state = ADD_B;
      ADD_B:   next_state = ADD_M;
      ADD_M:   next_state = SHIFT;
      SHIFT:   next_state = (bit_cnt == CNT_W'(N - 1)) ? RESOLVE : ADD_B;
      RESOLVE: if (phase_last) next_state = SUB;
      SUB: begin
        if (phase_last) begin
          if (add_carry) begin
            next_state = DONE;
          end else if (sub_cnt == SUB_W'(MAX_SUB - 1)) begin
            next_state = DONE;
            sub_fail   = 1'b1;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    ctrl_d.enable_c = (next_state == ADD_B) || (next_state == ADD_M);
    ctrl_d.shift    = (next_state == SHIFT);
    ctrl_d.subtract = (next_state == SUB);
    phase_hold      = !((next_state == RESOLVE) || (next_state == SUB));
  end

  // Operand mux; ADD_M depends on the accumulator parity in the same cycle.
  always_comb begin
    add_in_a = '0;
    case (state)
      ADD_B:   if (a_sr[0]) add_in_a = {2'b00, b_q};
      ADD_M:   if (add_cZero) add_in_a = {2'b00, m_q};
      SUB:     add_in_a = (~{2'b00, m_q}) + W_ADD'(1);
      default: add_in_a = '0;
    endcase
  end

  // Operand capture and multiplier shift register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_sr <= '0;
      b_q  <= '0;
      m_q  <= '0;
    end else if ((state == IDLE) && start) begin
      a_sr <= in_a;
      b_q  <= in_b;
      m_q  <= in_m;
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
    end
  end

  // Bit counter wraps to zero on the final shift; sweep counter restarts per product.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bit_cnt <= '0;
      sub_cnt <= '0;
    end else begin
      if (state == SHIFT) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (state == IDLE) begin
        sub_cnt <= '0;
      end else if ((state == SUB) && phase_last && !add_carry) begin
        sub_cnt <= sub_cnt + SUB_W'(1);
      end
    end
  end

  // Registered status, result and adder strobes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      ctrl_q <= '0;
    end else begin
      busy   <= (next_state != IDLE) && (next_state != DONE);
      done   <= (next_state == DONE);
      err    <= sub_fail;
      ctrl_q <= ctrl_d;
      if (next_state == DONE) begin
        result <= add_result[N-1:0];
      end
    end
  end

  assign add_enableC  = ctrl_q.enable_c;
  assign add_shift    = ctrl_q.shift;
  assign add_subtract = ctrl_q.subtract;

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// Bench for mont_mul_ctrl with a behavioural mpadder and a REDC-based golden model.
module tb_mont_mul_ctrl;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [511:0] in_a;
  logic [511:0] in_b;
  logic [511:0] in_m;
  logic         busy;
  logic         done;
  logic         err;
  logic [511:0] result;
  logic [513:0] add_in_a;
  logic         add_enableC;
  logic         add_shift;
  logic         add_subtract;
  logic [3:0]   add_phase;
  logic         add_cZero;
  logic         add_carry;
  logic [513:0] add_result;

  int n_cmp;
  int n_fail;

  // Behavioural mpadder: accumulate, halve, and conditionally subtract at phase 4.
  logic [513:0] acc;
  logic [511:0] cur_m;

  assign add_cZero  = acc[0];
  assign add_result = acc;
  assign add_carry  = add_subtract && (add_phase == 4'd4) && (acc < {2'b00, cur_m});

  always @(posedge clk) begin
    if (!resetn || done) acc <= '0;
    else if (add_enableC) acc <= acc + add_in_a;
    else if (add_shift) acc <= acc >> 1;
    else if (add_subtract && (add_phase == 4'd4) && !add_carry) acc <= acc + add_in_a;
  end

  mont_mul_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .result       (result),
    .add_in_a     (add_in_a),
    .add_enableC  (add_enableC),
    .add_shift    (add_shift),
    .add_subtract (add_subtract),
    .add_phase    (add_phase),
    .add_cZero    (add_cZero),
    .add_carry    (add_carry),
    .add_result   (add_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Golden: raw = (AB + qM)/2^512 with q = -AB*M^-1 mod 2^512; k sweeps = raw/M + 1.
  task automatic golden(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                        output logic [511:0] res, output int k, output logic e);
    logic [511:0]  inv;
    logic [511:0]  q;
    logic [1039:0] ab;
    logic [1039:0] raw;
    logic [1039:0] kn;
    inv = 512'd1;
    for (int i = 0; i < 10; i++) inv = inv * (512'd2 - m * inv);
    ab  = 1040'(a) * 1040'(b);
    q   = (512'd0 - ab[511:0]) * inv;
    raw = (ab + 1040'(q) * 1040'(m)) >> 512;
    kn  = raw / 1040'(m) + 1040'd1;
    e   = (kn > 1040'd4);
    k   = e ? 4 : int'(kn[3:0]);
    res = 512'(raw % 1040'(m));
  endtask

  // One product; optional second start at restart_cyc or reset at reset_cyc (cycle 1 = start cycle).
  task automatic run_op(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                        input int restart_cyc, input int reset_cyc, input string tag);
    logic [511:0] exp_res;
    logic [511:0] held;
    logic         exp_err;
    logic [3:0]   exp_ph;
    int           k;
    int           exp_lat;
    int           cyc;
    int           ph_bad;
    int           extra_done;
    bit           got_done;
    bit           overlap;
    bit           busy_drop;
    bit           busy_after;
    golden(a, b, m, exp_res, k, exp_err);
    exp_lat   = 1543 + 5 * k;
    cur_m     = m;
    in_a      = a;
    in_b      = b;
    in_m      = m;
    start     = 1'b1;
    cyc       = 1;
    got_done  = 1'b0;
    overlap   = 1'b0;
    busy_drop = 1'b0;
    ph_bad    = 0;
    while (!got_done && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == restart_cyc) begin
        start = 1'b1;
        in_a  = rnd512();
      end
      if (cyc == reset_cyc) begin
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check({tag, "_rst_busy"}, 512'(busy), 512'd0);
        check({tag, "_rst_result"}, result, 512'd0);
        check({tag, "_rst_phase"}, 512'(add_phase), 512'd8);
        check({tag, "_rst_done"}, 512'(done), 512'd0);
        return;
      end
      if (add_enableC && add_shift) overlap = 1'b1;
      exp_ph = (cyc >= 1538 && cyc < exp_lat) ? 4'((cyc - 1538) % 5) : 4'd8;
      if (add_phase !== exp_ph) ph_bad++;
      if (done) got_done = 1'b1;
      else if (!busy) busy_drop = 1'b1;
    end
    check({tag, "_latency"}, 512'(cyc), 512'(exp_lat));
    if (!got_done) begin
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      return;
    end
    if (!exp_err) check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, 512'(err), 512'(exp_err));
    check({tag, "_en_shift_overlap"}, 512'(overlap), 512'd0);
    check({tag, "_phase_trace_bad"}, 512'(ph_bad), 512'd0);
    check({tag, "_busy_dropped"}, 512'(busy_drop), 512'd0);
    // A start coinciding with done must be ignored.
    held  = result;
    start = 1'b1;
    in_a  = rnd512();
    @(posedge clk); #1;
    start      = 1'b0;
    busy_after = busy;
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
      if (busy) busy_after = 1'b1;
    end
    check({tag, "_start_at_done_busy"}, 512'(busy_after), 512'd0);
    check({tag, "_extra_done"}, 512'(extra_done), 512'd0);
    check({tag, "_result_held"}, result, held);
  endtask

  initial begin
    logic [511:0] a;
    logic [511:0] b;
    logic [511:0] m;
    logic [511:0] mersenne;
    n_cmp  = 0;
    n_fail = 0;
    resetn = 1'b0;
    start  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_m   = '0;
    cur_m  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 512'(busy), 512'd0);
    check("reset_done", 512'(done), 512'd0);
    check("reset_err", 512'(err), 512'd0);
    check("reset_result", result, 512'd0);
    check("reset_phase", 512'(add_phase), 512'd8);
    check("reset_strobes", 512'({add_enableC, add_shift, add_subtract}), 512'd0);
    check("reset_in_a", 512'(add_in_a), 512'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    mersenne = '0;
    mersenne[510:0] = '1;

    // A=1, B=1, M=3: 2^-512 mod 3 = 1 with a single subtract sweep.
    run_op(512'd1, 512'd1, 512'd3, 0, 0, "one");
    check("one_result_const", result, 512'd1);

    run_op(512'd0, rnd512() % mersenne, mersenne, 0, 0, "zero_a");
    check("zero_a_result_const", result, 512'd0);

    a = mersenne - 512'd1;
    run_op(a, a, mersenne, 0, 0, "big");

    // Second start while busy.
    run_op(rnd512() % mersenne, rnd512() % mersenne, mersenne, 100, 0, "restart");

    // Reset mid-product, then a fresh product.
    run_op(rnd512() % mersenne, rnd512() % mersenne, mersenne, 0, 700, "midreset");
    run_op(rnd512() % mersenne, rnd512() % mersenne, mersenne, 0, 0, "after_reset");

    // Out-of-range operands exhaust the subtract sweeps and raise err.
    a = '1;
    run_op(a, a, 512'd3, 0, 0, "err");

    for (int t = 0; t < 18; t++) begin
      m = rnd512();
      m[511] = 1'b0;
      m[0]   = 1'b1;
      if (m < 512'd3) m = 512'd3;
      a = rnd512() % m;
      b = rnd512() % m;
      run_op(a, b, m, 0, 0, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
